// File: rtl/booth_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_arbiter_if
// Brief    : Requester and multiplier-side signal bundle for booth_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface booth_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ*WIDTH-1:0] req_y;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [2*WIDTH-1:0]     result;
    logic                   busy;
    logic [WIDTH-1:0]       mult_x;
    logic [WIDTH-1:0]       mult_y;
    logic                   mult_start;
    logic [2*WIDTH-1:0]     mult_p;

    // Requesters plus the booth datapath; they drive the arbiter's inputs.
    modport master (
        output req, req_x, req_y, mult_p,
        input  grant, done, result, busy, mult_x, mult_y, mult_start
    );

    modport slave (
        input  req, req_x, req_y, mult_p,
        output grant, done, result, busy, mult_x, mult_y, mult_start
    );
endinterface
`default_nettype wire

// File: rtl/booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : booth_arbiter
// Brief    : Shares one booth multiplier among N_REQ requesters.
//            BOOTH_ARB_RR_EN selects round-robin (default: fixed priority).
// Revision : 1.0  initial release
// ============================================================================
module booth_arbiter #(
    parameter int WIDTH    = 4,
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    booth_arbiter_if.slave  bus
);
    localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CW = $clog2(MULT_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [N_REQ-1:0]   r_grant, w_grant;
    logic [N_REQ-1:0]   r_done,  w_done;
    logic [2*WIDTH-1:0] r_result, w_result;
    logic [WIDTH-1:0]   r_mult_x, w_mult_x;
    logic [WIDTH-1:0]   r_mult_y, w_mult_y;
    logic               r_start, w_start;
    logic [c_CW-1:0]    r_cnt,   w_cnt;
    logic [c_PW-1:0]    w_win;
    logic               w_any;
`ifdef BOOTH_ARB_RR_EN
    logic [c_PW-1:0]    r_ptr,  w_ptr;
    logic [c_PW-1:0]    r_gidx, w_gidx;
`endif

    // Winner: lowest set index; in round-robin mode, the lowest set index at
    // or above the pointer overrides it, wrapping to the lowest overall.
    always_comb begin
        w_any = |bus.req;
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) w_win = c_PW'(i);
        end
`ifdef BOOTH_ARB_RR_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i] && (c_PW'(i) >= r_ptr)) w_win = c_PW'(i);
        end
`endif
    end

    always_comb begin
        w_state  = r_state;
        w_grant  = r_grant;
        w_done   = '0;
        w_result = r_result;
        w_mult_x = r_mult_x;
        w_mult_y = r_mult_y;
        w_start  = 1'b0;
        w_cnt    = r_cnt;
`ifdef BOOTH_ARB_RR_EN
        w_ptr    = r_ptr;
        w_gidx   = r_gidx;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state = S_LOAD;
                    w_start = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        w_grant[i] = (w_win == c_PW'(i));
                        if (w_win == c_PW'(i)) begin
                            w_mult_x = bus.req_x[i*WIDTH +: WIDTH];
                            w_mult_y = bus.req_y[i*WIDTH +: WIDTH];
                        end
                    end
`ifdef BOOTH_ARB_RR_EN
                    w_gidx = w_win;
`endif
                end
            end
            S_LOAD: begin
                w_cnt   = '0;
                w_state = S_WAIT;
            end
            S_WAIT: begin
                w_cnt = r_cnt + 1'b1;
                // Capture on the edge into DONE so result and done appear together.
                if (r_cnt == c_CW'(MULT_LAT - 1)) begin
                    w_state  = S_DONE;
                    w_result = bus.mult_p;
                    w_done   = r_grant;
                end
            end
            S_DONE: begin
                w_grant = '0;
                w_state = S_IDLE;
`ifdef BOOTH_ARB_RR_EN
                w_ptr = (r_gidx == c_PW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
`endif
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_mult_x <= '0;
            r_mult_y <= '0;
            r_start  <= 1'b0;
            r_cnt    <= '0;
`ifdef BOOTH_ARB_RR_EN
            r_ptr    <= '0;
            r_gidx   <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_grant  <= w_grant;
            r_done   <= w_done;
            r_result <= w_result;
            r_mult_x <= w_mult_x;
            r_mult_y <= w_mult_y;
            r_start  <= w_start;
            r_cnt    <= w_cnt;
`ifdef BOOTH_ARB_RR_EN
            r_ptr    <= w_ptr;
            r_gidx   <= w_gidx;
`endif
        end
    end

    assign bus.grant      = r_grant;
    assign bus.done       = r_done;
    assign bus.result     = r_result;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mult_x     = r_mult_x;
    assign bus.mult_y     = r_mult_y;
    assign bus.mult_start = r_start;
endmodule
`default_nettype wire

// File: tb/tb_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_arbiter
// Brief    : Directed self-checking bench for booth_arbiter with a booth model.
// Revision : 1.0  initial release
// ============================================================================
module tb_booth_arbiter;
    localparam int WIDTH    = 4;
    localparam int N_REQ    = 4;
    localparam int MULT_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    booth_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

    booth_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .MULT_LAT(MULT_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Booth multiplier stand-in: product appears MULT_LAT cycles after start,
    // with a junk value on mult_p until then.
    int                        bcnt = 0;
    logic signed [2*WIDTH-1:0] bpend = '0;
    always @(posedge clk) begin
        if (rst) begin
            bcnt        <= 0;
            bus.mult_p  <= 8'hA5;
        end else if (bus.mult_start) begin
            bcnt        <= MULT_LAT - 1;
            bpend       <= $signed(bus.mult_x) * $signed(bus.mult_y);
            bus.mult_p  <= 8'hA5;
        end else if (bcnt > 0) begin
            if (bcnt == 1) bus.mult_p <= bpend;
            bcnt <= bcnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req   = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for any done pulse; returns cycles taken and the done vector (0 on timeout).
    task automatic wait_done(input int limit, output int cyc, output logic [N_REQ-1:0] d);
        cyc = 0;
        d   = '0;
        while (cyc < limit) begin
            tick();
            cyc++;
            if (bus.done !== '0) begin
                d = bus.done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.grant !== 4'b0)   begin errors++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
        checks++; if (bus.done !== 4'b0)    begin errors++; $display("FAIL reset_done got %b want 0000", bus.done); end
        checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", bus.result); end
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if ({bus.mult_x, bus.mult_y, bus.mult_start} !== 9'b0)
            begin errors++; $display("FAIL reset_mult got %h %h %b want 0 0 0", bus.mult_x, bus.mult_y, bus.mult_start); end
    endtask

    task automatic test_single();
        int dcount;
        do_reset();
        bus.req_x[3:0] = 4'b0010;
        bus.req_y[3:0] = 4'b0010;
        bus.req        = 4'b0001;
        tick();  // cycle 1: LOAD
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", bus.grant); end
        checks++; if (bus.mult_start !== 1'b1 || bus.busy !== 1'b1)
            begin errors++; $display("FAIL single_load got start=%b busy=%b want 1 1", bus.mult_start, bus.busy); end
        checks++; if (bus.mult_x !== 4'b0010 || bus.mult_y !== 4'b0010)
            begin errors++; $display("FAIL single_operands got %b %b want 0010 0010", bus.mult_x, bus.mult_y); end
        dcount = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (bus.done !== 4'b0 || bus.mult_start !== 1'b0 || bus.grant !== 4'b0001) dcount++;
        end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL single_wait got %0d bad cycles want 0", dcount); end
        tick();  // cycle 6: DONE
        checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL single_done got %b want 0001", bus.done); end
        checks++; if (bus.result !== 8'b00000100) begin errors++; $display("FAIL single_result got %b want 00000100", bus.result); end
        bus.req = 4'b0000;
        tick();  // cycle 7: IDLE
        checks++; if (bus.done !== 4'b0 || bus.grant !== 4'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL single_idle got done=%b grant=%b busy=%b want 0000 0000 0", bus.done, bus.grant, bus.busy); end
        checks++; if (bus.result !== 8'b00000100) begin errors++; $display("FAIL single_hold got %b want 00000100", bus.result); end
    endtask

    task automatic test_signed();
        logic [3:0] xs [2] = '{4'b1101, 4'b1000};
        logic [3:0] ys [2] = '{4'b0101, 4'b1000};
        logic [7:0] ps [2] = '{8'b11110001, 8'b01000000};
        int cyc;
        logic [N_REQ-1:0] d;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            bus.req_x[3:0] = xs[k];
            bus.req_y[3:0] = ys[k];
            bus.req        = 4'b0001;
            wait_done(30, cyc, d);
            checks++; if (d !== 4'b0001 || cyc !== 6) begin errors++; $display("FAIL signed_done%0d got %b at %0d want 0001 at 6", k, d, cyc); end
            checks++; if (bus.result !== ps[k]) begin errors++; $display("FAIL signed_result%0d got %b want %b", k, bus.result, ps[k]); end
            bus.req = 4'b0000;
            tick();
        end
    endtask

    task automatic test_simultaneous();
        int cyc;
        logic [N_REQ-1:0] d;
        do_reset();
        bus.req_x[3:0] = 4'd1; bus.req_y[3:0] = 4'd3;
        bus.req_x[7:4] = 4'd2; bus.req_y[7:4] = 4'd3;
        bus.req = 4'b0011;
        wait_done(30, cyc, d);
        checks++; if (d !== 4'b0001 || cyc !== 6) begin errors++; $display("FAIL simul_first got %b at %0d want 0001 at 6", d, cyc); end
        checks++; if (bus.result !== 8'h03) begin errors++; $display("FAIL simul_result0 got %h want 03", bus.result); end
        bus.req = 4'b0010;
        wait_done(30, cyc, d);
        checks++; if (d !== 4'b0010 || cyc !== MULT_LAT + 3) begin errors++; $display("FAIL simul_second got %b at +%0d want 0010 at +7", d, cyc); end
        checks++; if (bus.result !== 8'h06) begin errors++; $display("FAIL simul_result1 got %h want 06", bus.result); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_all_held();
`ifdef BOOTH_ARB_RR_EN
        logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] prod  [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1};
`else
        logic [3:0] order [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic [7:0] prod  [5] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
`endif
        int cyc;
        logic [N_REQ-1:0] d;
        do_reset();
        bus.req_x = {4'd4, 4'd3, 4'd2, 4'd1};
        bus.req_y = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(30, cyc, d);
            checks++; if (d !== order[k]) begin errors++; $display("FAIL held_order%0d got %b want %b", k, d, order[k]); end
            checks++; if (bus.result !== prod[k]) begin errors++; $display("FAIL held_result%0d got %h want %h", k, bus.result, prod[k]); end
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_abort();
        int cyc;
        int seen;
        logic [N_REQ-1:0] d;
        bus.req_x[3:0] = 4'd3;
        bus.req_y[3:0] = 4'd2;
        bus.req        = 4'b0001;
        tick(); tick(); tick();  // cycle 3: second WAIT cycle
        checks++; if (bus.busy !== 1'b1 || bus.grant !== 4'b0001)
            begin errors++; $display("FAIL abort_pre got busy=%b grant=%b want 1 0001", bus.busy, bus.grant); end
        rst = 1'b1;
        bus.req = 4'b0000;
        tick();
        rst = 1'b0;
        checks++; if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.mult_start !== 1'b0 || bus.result !== 8'h00)
            begin errors++; $display("FAIL abort_state got grant=%b busy=%b start=%b result=%h want 0 0 0 00", bus.grant, bus.busy, bus.mult_start, bus.result); end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.done !== 4'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_nodone got %0d pulses want 0", seen); end
        bus.req = 4'b0001;
        wait_done(30, cyc, d);
        checks++; if (d !== 4'b0001 || cyc !== 6 || bus.result !== 8'h06)
            begin errors++; $display("FAIL abort_recover got %b at %0d result %h want 0001 at 6 result 06", d, cyc, bus.result); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_drop_in_load();
        int cyc;
        logic [N_REQ-1:0] d;
        do_reset();
        bus.req_x[11:8] = 4'b0011;
        bus.req_y[11:8] = 4'b0011;
        bus.req         = 4'b0100;
        tick();  // cycle 1: LOAD
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL drop_grant got %b want 0100", bus.grant); end
        bus.req = 4'b0000;
        tick();  // cycle 2: WAIT
        bus.req_x[11:8] = 4'b0111;
        bus.req_y[11:8] = 4'b0111;
        wait_done(30, cyc, d);
        checks++; if (d !== 4'b0100 || cyc !== 4) begin errors++; $display("FAIL drop_done got %b at +%0d want 0100 at +4", d, cyc); end
        checks++; if (bus.result !== 8'b00001001) begin errors++; $display("FAIL drop_result got %b want 00001001", bus.result); end
        tick();
    endtask

    initial begin
        bus.req   = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        test_reset();
        test_single();
        test_signed();
        test_simultaneous();
        test_all_held();
        test_reset_abort();
        test_drop_in_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
